// File: rtl/calc_key_sequencer.sv
// ---------------------------------------------------------------------------
// calc_key_sequencer
//
// Scans a 4x4 calculator keypad and debounces key presses. It turns the
// keystrokes into framed write and clear commands for the calculator memory
// stage: operand A digits, the operator, operand B digits, and a final
// display select for the result.
//
// Parameters
//   SCAN_DIV        cycles each column is driven while scanning (must be > 2)
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a press/release
//   MAX_DIGITS      maximum digits accepted per operand
//
// Ports
//   clk         system clock
//   reset       asynchronous active-high reset
//   row[3:0]    keypad row sense, active-high, asynchronous
//   col[3:0]    keypad column drive, one-hot
//   dataIn[3:0] digit value or key code for the memory stage
//   memSet      one-cycle write strobe
//   memClr      one-cycle clear strobe
//   memLoc[1:0] write target: 00 = A, 01 = B, 10 = op
//   memDisplay  display select: 00 = A, 01 = B, 10 = result
//
// Optional build macro KEYSEQ_KEYCODE_OUT_EN adds:
//   key_code[3:0] last accepted key code
//   key_strobe    one-cycle pulse per accepted key, including ignored keys
//
// Key codes: digits 0-9 as their value, A-D = 0xA-0xD, * = 0xE, # = 0xF.
// ---------------------------------------------------------------------------
module calc_key_sequencer #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_DIGITS      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] dataIn,
  output logic       memSet,
  output logic       memClr,
  output logic [1:0] memLoc,
  output logic [1:0] memDisplay
`ifdef KEYSEQ_KEYCODE_OUT_EN
  ,
  output logic [3:0] key_code,
  output logic       key_strobe
`endif
);

  localparam int SCW = $clog2(SCAN_DIV + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW  = $clog2(MAX_DIGITS + 1);

  localparam logic [SCW-1:0] SCAN_LAST   = SCW'(SCAN_DIV - 1);
  // Rows seen through the synchroniser lag the column drive by two cycles.
  localparam logic [SCW-1:0] SYNC_SETTLE = SCW'(2);
  localparam logic [DBW-1:0] DEB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX     = CW'(MAX_DIGITS);

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [1:0] LOC_A    = 2'b00;
  localparam logic [1:0] LOC_B    = 2'b01;
  localparam logic [1:0] LOC_OP   = 2'b10;
  localparam logic [1:0] DISP_RES = 2'b10;

  typedef enum logic [1:0] {SC_ROTATE, SC_PRESS, SC_RELEASE} scan_state_e;
  typedef enum logic [1:0] {ENTER_A, ENTER_B, SHOW_RES, PEND_A} entry_state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_ARM, PH_STROBE, PH_HOLD} phase_e;

  function automatic logic [3:0] key_decode(input logic [3:0] rc);
    logic [3:0] k;
    case (rc)
      4'd0:    k = 4'h1;
      4'd1:    k = 4'h2;
      4'd2:    k = 4'h3;
      4'd3:    k = 4'hA;
      4'd4:    k = 4'h4;
      4'd5:    k = 4'h5;
      4'd6:    k = 4'h6;
      4'd7:    k = 4'hB;
      4'd8:    k = 4'h7;
      4'd9:    k = 4'h8;
      4'd10:   k = 4'h9;
      4'd11:   k = 4'hC;
      4'd12:   k = KEY_STAR;
      4'd13:   k = 4'h0;
      4'd14:   k = KEY_HASH;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  // -------------------------------------------------------------------------
  // Row synchroniser
  // -------------------------------------------------------------------------
  logic [3:0] row_s1_q, row_s2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, whatever order the blocks execute in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q <= '0;
      row_s2_q <= '0;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Scanner and debouncer
  // -------------------------------------------------------------------------
  scan_state_e    scan_state_q, scan_state_d;
  logic [3:0]     col_q, col_d;
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
  logic [4:0]     trk_q, trk_d;      // {valid, row index, col index}
  logic           key_evt_q, key_evt_d;
  logic [3:0]     key_val_q, key_val_d;

  logic [1:0] row_idx, col_idx;
  logic [4:0] cand;

  // Lowest row index wins when several rows are high.
  always_comb begin
    row_idx = 2'd0;
    if (row_s2_q[0])      row_idx = 2'd0;
    else if (row_s2_q[1]) row_idx = 2'd1;
    else if (row_s2_q[2]) row_idx = 2'd2;
    else if (row_s2_q[3]) row_idx = 2'd3;
    col_idx = 2'd0;
    case (col_q)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    // "No row" is tracked as a code of its own, so a bounce to open simply
    // restarts the count while the column stays held.
    cand = (|row_s2_q) ? {1'b1, row_idx, col_idx} : 5'b0;
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    scan_state_d = scan_state_q;
    col_d        = col_q;
    scan_cnt_d   = scan_cnt_q;
    deb_cnt_d    = deb_cnt_q;
    trk_d        = trk_q;
    key_evt_d    = 1'b0;
    key_val_d    = key_val_q;
    case (scan_state_q)
      SC_ROTATE: begin
        if (cand[4] && scan_cnt_q >= SYNC_SETTLE) begin
          scan_state_d = SC_PRESS;
          trk_d        = cand;
          deb_cnt_d    = DBW'(1);
          scan_cnt_d   = '0;
        end else if (scan_cnt_q >= SCAN_LAST) begin
          scan_cnt_d = '0;
          col_d      = {col_q[2:0], col_q[3]};
        end else begin
          scan_cnt_d = scan_cnt_q + SCW'(1);
        end
      end
      SC_PRESS: begin
        if (cand == trk_q) begin
          if (deb_cnt_q >= DEB_LAST) begin
            deb_cnt_d = '0;
            if (trk_q[4]) begin
              key_evt_d    = 1'b1;
              key_val_d    = key_decode(trk_q[3:0]);
              scan_state_d = SC_RELEASE;
            end else begin
              scan_state_d = SC_ROTATE;
            end
          end else begin
            deb_cnt_d = deb_cnt_q + DBW'(1);
          end
        end else begin
          trk_d     = cand;
          deb_cnt_d = DBW'(1);
        end
      end
      SC_RELEASE: begin
        if (cand[4]) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          deb_cnt_d    = '0;
          scan_cnt_d   = '0;
          scan_state_d = SC_ROTATE;
        end else begin
          deb_cnt_d = deb_cnt_q + DBW'(1);
        end
      end
      default: scan_state_d = SC_ROTATE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_state_q <= SC_ROTATE;
      col_q        <= 4'b0001;
      scan_cnt_q   <= '0;
      deb_cnt_q    <= '0;
      trk_q        <= '0;
      key_evt_q    <= 1'b0;
      key_val_q    <= '0;
    end else begin
      scan_state_q <= scan_state_d;
      col_q        <= col_d;
      scan_cnt_q   <= scan_cnt_d;
      deb_cnt_q    <= deb_cnt_d;
      trk_q        <= trk_d;
      key_evt_q    <= key_evt_d;
      key_val_q    <= key_val_d;
    end
  end

  // -------------------------------------------------------------------------
  // Entry FSM and write/clear framing
  // -------------------------------------------------------------------------
  entry_state_e state_q, state_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [3:0]    pend_q, pend_d;
  logic [3:0]    data_q, data_d;
  logic [1:0]    loc_q, loc_d;
  logic [1:0]    disp_q, disp_d;
  phase_e        wr_ph_q, wr_ph_d, clr_ph_q, clr_ph_d;
  logic          set_q, set_d, clr_q, clr_d;

  logic is_digit, is_op;
  assign is_digit = (key_val_q <= 4'd9);
  assign is_op    = (key_val_q >= 4'hA) && (key_val_q <= 4'hD);

  always_comb begin
    state_d = state_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    pend_d  = pend_q;
    data_d  = data_q;
    loc_d   = loc_q;
    // A frame runs ARM (data/loc valid) -> STROBE (memSet) -> HOLD -> IDLE.
    case (wr_ph_q)
      PH_ARM:    wr_ph_d = PH_STROBE;
      PH_STROBE: wr_ph_d = PH_HOLD;
      default:   wr_ph_d = PH_IDLE;
    endcase
    clr_ph_d = (clr_ph_q == PH_ARM) ? PH_STROBE : PH_IDLE;
    set_d    = (wr_ph_q == PH_ARM);
    clr_d    = (clr_ph_q == PH_ARM);

    if (key_evt_q && key_val_q == KEY_STAR) begin
      clr_ph_d = PH_ARM;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
      state_d  = ENTER_A;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (key_evt_q) begin
            if (is_digit && cnt_a_q < CNT_MAX) begin
              data_d  = key_val_q;
              loc_d   = LOC_A;
              wr_ph_d = PH_ARM;
              cnt_a_d = cnt_a_q + CW'(1);
            end else if (is_op && cnt_a_q != '0) begin
              data_d  = key_val_q;
              loc_d   = LOC_OP;
              wr_ph_d = PH_ARM;
              state_d = ENTER_B;
            end
          end
        end
        ENTER_B: begin
          if (key_evt_q) begin
            if (is_digit && cnt_b_q < CNT_MAX) begin
              data_d  = key_val_q;
              loc_d   = LOC_B;
              wr_ph_d = PH_ARM;
              cnt_b_d = cnt_b_q + CW'(1);
            end else if (is_op && cnt_b_q == '0) begin
              data_d  = key_val_q;
              loc_d   = LOC_OP;
              wr_ph_d = PH_ARM;
            end else if (key_val_q == KEY_HASH && cnt_b_q != '0) begin
              state_d = SHOW_RES;
            end
          end
        end
        SHOW_RES: begin
          if (key_evt_q && is_digit) begin
            clr_ph_d = PH_ARM;
            cnt_a_d  = '0;
            cnt_b_d  = '0;
            pend_d   = key_val_q;
            state_d  = PEND_A;
          end
        end
        PEND_A: begin
          // Wait until the clear strobe has come and gone before starting
          // the frame, so memSet never overlaps memClr.
          if (clr_ph_q == PH_IDLE) begin
            data_d  = pend_q;
            loc_d   = LOC_A;
            wr_ph_d = PH_ARM;
            cnt_a_d = CW'(1);
            state_d = ENTER_A;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end

    case (state_d)
      ENTER_B:  disp_d = LOC_B;
      SHOW_RES: disp_d = DISP_RES;
      default:  disp_d = LOC_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ENTER_A;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      pend_q   <= '0;
      data_q   <= '0;
      loc_q    <= LOC_A;
      disp_q   <= LOC_A;
      wr_ph_q  <= PH_IDLE;
      clr_ph_q <= PH_IDLE;
      set_q    <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
      loc_q    <= loc_d;
      disp_q   <= disp_d;
      wr_ph_q  <= wr_ph_d;
      clr_ph_q <= clr_ph_d;
      set_q    <= set_d;
      clr_q    <= clr_d;
    end
  end

  assign col        = col_q;
  assign dataIn     = data_q;
  assign memSet     = set_q;
  assign memClr     = clr_q;
  assign memLoc     = loc_q;
  assign memDisplay = disp_q;

`ifdef KEYSEQ_KEYCODE_OUT_EN
  assign key_code   = key_val_q;
  assign key_strobe = key_evt_q;
`endif

endmodule
